lcd_ctrl: RTL
=============

Name: lcd_ctrl

Overview:
Parametrised HD44780-class character-LCD write controller. It replaces the fixed-timing, 8-bit, control-code-driven LCD writer.
- Accepts {rs, data} write requests over a valid/ready handshake into a small command FIFO.
- Serialises each request onto the LCD bus in 8-bit or 4-bit (nibble) mode with programmable setup, enable-width, hold and execution delays.
- Clear/home instructions get an extended execution wait.
- Sits between the bus-register interface and the LCD pins.

Parameters:
- BUS_W, 8, LCD data-bus width; legal values 8 or 4.
- DEPTH, 4, command FIFO depth; power of two, ≥2.
- SETUP_CYC, 2, cycles RS/data are stable before E rises; ≥1.
- PW_CYC, 9, E high width in cycles; ≥1.
- HOLD_CYC, 2, cycles data is held after E falls; ≥1.
- EXEC_CYC, 66, post-transfer wait for normal instructions and data; ≥1.
- LONG_CYC, 2000, post-transfer wait for clear (0x01) and home (0x02/0x03) instructions; ≥ EXEC_CYC.
- CNT_W, 8, width of done_cnt.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_rs  in  1  0 = instruction, 1 = data
- req_data  in  8  byte to write
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  tied 0 (write only)
- lcd_e  out  1  LCD enable
- lcd_d  out  BUS_W  LCD data bus
- busy  out  1  FIFO non-empty or FSM not IDLE
- done  out  1  one-cycle pulse per completed request
- done_cnt  out  CNT_W  completed-request counter; wraps
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset==0 at posedge): FIFO flushed; FSM to IDLE; lcd_rs=0, lcd_e=0, lcd_d=0, done=0, done_cnt=0, busy=0, req_ready=1. Takes effect at that edge even mid-transfer; lcd_e drops immediately.
- All outputs are registered except req_ready, busy and fifo_level, which are decoded from registered state.
- Handshake: push when req_valid && req_ready at a posedge. req_ready = (level != DEPTH). When full, req_valid is ignored with no side effects. The FIFO has no fall-through.
- FSM states: IDLE, SETUP, EN_HI, HOLD, WAIT.
  - A single down-counter is loaded with N-1 on phase entry, so each phase lasts exactly N cycles.
- IDLE: if the FIFO is non-empty at edge E1, pop it, latch rs/data, drive lcd_rs and lcd_d, and enter SETUP.
  - With BUS_W==4, lcd_d = data[7:4] first.
  - Minimum latency from the acceptance edge E0 to E1 is 1 cycle.
- SETUP (SETUP_CYC) -> EN_HI; lcd_e=1 for PW_CYC cycles.
- EN_HI -> HOLD; lcd_e=0, lcd_d and lcd_rs unchanged, for HOLD_CYC cycles.
- HOLD exit:
  - BUS_W==4 and high nibble just sent: drive data[3:0] and re-enter SETUP.
  - Otherwise: enter WAIT.
- WAIT duration:
  - LONG_CYC if rs==0 and data ∈ {0x01, 0x02, 0x03}.
  - EXEC_CYC otherwise.
- WAIT exit: done=1 for one cycle, done_cnt+1 (modulo 2^CNT_W), FSM to IDLE.
  - IDLE may pop the next entry on the following edge, giving one idle cycle between requests.
- lcd_rs and lcd_d hold their last values in IDLE (no glitch to 0).
- Total cycles from E1 to done assertion:
  - 8-bit: SETUP+PW+HOLD+WAIT.
  - 4-bit: 2*(SETUP+PW+HOLD)+WAIT.
- Simultaneous push and pop:
  - Both take effect; level unchanged.
  - A push into an empty FIFO is not visible to IDLE until the next cycle.
- Illegal BUS_W values are rejected by an elaboration-time assertion.

Decomposition:
- Package lcd_ctrl_pkg:
  - FSM state enum.
  - Clear/home opcode constants 8'h01, 8'h02, 8'h03.
  - Function is_long_cmd(rs, data).
- Sub-module lcd_cmd_fifo: synchronous FIFO of 9-bit entries {rs, data}, parametrised by DEPTH, with push/pop/full/empty/level.
- The FSM and the timing counter remain in lcd_ctrl.

Test Plan:
Common parameters: SETUP=2, PW=3, HOLD=2, EXEC=5, LONG=20, DEPTH=4.
1. BUS_W=8, push {rs=1, 0x41} -> lcd_rs=1, lcd_d=0x41. lcd_e high exactly 3 cycles starting 2 cycles after E1. done pulses 12 cycles after E1. done_cnt=1.
2. BUS_W=4, push {rs=1, 0xA5} -> two E pulses, with lcd_d=0xA then 0x5. done 19 cycles after E1.
3. Push {rs=0, 0x01} -> WAIT lasts 20 cycles. Then push {rs=1, 0x01} -> WAIT lasts 5 cycles (data byte, not a long command).
4. Hold req_valid high with 6 back-to-back requests -> req_ready drops once level=4. All 6 bytes appear on lcd_d in order. done_cnt=6. busy falls after the last done.
5. Drive reset low while lcd_e=1 mid-transfer with 2 entries queued -> next edge: lcd_e=0, fifo_level=0, done_cnt=0, busy=0. No done pulse follows.
6. With CNT_W=2, complete 5 requests -> done_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// Shared types and opcode helpers for the character-LCD write controller.
// Imported by the command FIFO, the request interface users and the top.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    WAIT
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  // Clear and home need the long execution wait; data bytes never do.
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data == OP_CLEAR ||
                   data == OP_HOME  ||
                   data == OP_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Write-request handshake between the register block and the LCD controller.
// The master offers {rs, data}; the slave accepts when ready.
interface lcd_ctrl_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (
    output req_valid,
    output req_rs,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rs,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO of {rs, data} LCD commands.
// Registered occupancy; a push into an empty FIFO is seen one cycle later.
module lcd_cmd_fifo
  import lcd_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   din,
  input  logic                   pop,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-class LCD write controller: queues {rs, data} requests and
// serialises them onto an 8-bit or 4-bit bus with programmable timing.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int BUS_W     = 8,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int PW_CYC    = 9,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 66,
  parameter int LONG_CYC  = 2000,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  lcd_ctrl_if.slave              req,
  output logic                   lcd_rs,
  output logic                   lcd_rw,
  output logic                   lcd_e,
  output logic [BUS_W-1:0]       lcd_d,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       done_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  if (BUS_W != 8 && BUS_W != 4) begin : g_bad_bus
    $error("lcd_ctrl: BUS_W must be 8 or 4");
  end

  localparam int M1 = (SETUP_CYC > PW_CYC) ? SETUP_CYC : PW_CYC;
  localparam int M2 = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
  localparam int M3 = (M2 > LONG_CYC) ? M2 : LONG_CYC;
  localparam int TW = $clog2(M3 + 1);

  state_t        state;
  logic [TW-1:0] tmr;
  cmd_t          cur;
  cmd_t          head;
  logic          lo_nib;
  logic          fifo_full;
  logic          fifo_empty;
  logic          tmr_done;

  assign tmr_done      = (tmr == '0);
  assign req.req_ready = !fifo_full;
  assign busy          = !fifo_empty || (state != IDLE);
  assign lcd_rw        = 1'b0;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req.req_valid),
    .din   ({req.req_rs, req.req_data}),
    .pop   (state == IDLE),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Each phase loads N-1 and runs until the timer reaches zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tmr      <= '0;
      cur      <= '0;
      lo_nib   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_d    <= '0;
      done     <= 1'b0;
      done_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && !tmr_done) tmr <= tmr - 1'b1;
      unique case (state)
        IDLE: if (!fifo_empty) begin
          cur    <= head;
          lcd_rs <= head.rs;
          lcd_d  <= head.data[7 -: BUS_W];
          lo_nib <= 1'b0;
          tmr    <= TW'(SETUP_CYC - 1);
          state  <= SETUP;
        end
        SETUP: if (tmr_done) begin
          lcd_e <= 1'b1;
          tmr   <= TW'(PW_CYC - 1);
          state <= EN_HI;
        end
        EN_HI: if (tmr_done) begin
          lcd_e <= 1'b0;
          tmr   <= TW'(HOLD_CYC - 1);
          state <= HOLD;
        end
        HOLD: if (tmr_done) begin
          if (BUS_W == 4 && !lo_nib) begin
            lo_nib <= 1'b1;
            lcd_d  <= cur.data[BUS_W-1:0];
            tmr    <= TW'(SETUP_CYC - 1);
            state  <= SETUP;
          end else begin
            tmr   <= is_long_cmd(cur.rs, cur.data) ?
                     TW'(LONG_CYC - 1) : TW'(EXEC_CYC - 1);
            state <= WAIT;
          end
        end
        WAIT: if (tmr_done) begin
          done     <= 1'b1;
          done_cnt <= done_cnt + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
